// File: rtl/regfile_write_scheduler_if.sv
// Write-port sharing bundle: two requesters plus the CLEAR control,
// and the registered write bundle that drives the register file.
interface regfile_write_scheduler_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  Req0, Req1;
  logic [ADDR_WIDTH-1:0] Addr0, Addr1;
  logic [DATA_WIDTH-1:0] Data0, Data1;
  logic                  Gnt0, Gnt1;
  logic                  Clr_Start, Busy, Clr_Done;
  logic                  Write;
  logic [ADDR_WIDTH-1:0] Write_Reg;
  logic [DATA_WIDTH-1:0] Write_Data;

  modport master (
    output Req0, Addr0, Data0, Req1, Addr1, Data1, Clr_Start,
    input  Gnt0, Gnt1, Busy, Clr_Done, Write, Write_Reg, Write_Data
  );

  modport slave (
    input  Req0, Addr0, Data0, Req1, Addr1, Data1, Clr_Start,
    output Gnt0, Gnt1, Busy, Clr_Done, Write, Write_Reg, Write_Data
  );
endinterface

// File: rtl/regfile_write_scheduler.sv
// Round-robin scheduler for the register file's single write port, with a
// CLEAR sequence that zeroes every register one address per cycle.
module regfile_write_scheduler #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter bit ZERO_PROTECT = 1'b1
) (
  input logic                    CLK,
  input logic                    RST,
  regfile_write_scheduler_if.slave bus
);
  typedef enum logic {ARB, CLEAR} state_t;
  localparam logic [ADDR_WIDTH-1:0] CNT_MAX = '1;

  state_t                state_q, state_d;
  logic                  last_gnt_q, last_gnt_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] write_reg_q, write_reg_d;
  logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
  logic                  clr_done_q, clr_done_d;

  logic [1:0]                 req, gnt;
  logic [1:0][ADDR_WIDTH-1:0] addr;
  logic [1:0][DATA_WIDTH-1:0] wdata;
  logic                       arb_ok, gidx;

  assign req   = {bus.Req1, bus.Req0};
  assign addr  = {bus.Addr1, bus.Addr0};
  assign wdata = {bus.Data1, bus.Data0};

  // Clr_Start pre-empts arbitration, so no grant leaks out on the start cycle.
  assign arb_ok = (state_q == ARB) && !bus.Clr_Start;
  assign gnt[0] = arb_ok && req[0] && (!req[1] || last_gnt_q);
  assign gnt[1] = arb_ok && req[1] && (!req[0] || !last_gnt_q);
  assign gidx   = gnt[1];

  always_comb begin
    state_d      = state_q;
    last_gnt_d   = last_gnt_q;
    clr_cnt_d    = clr_cnt_q;
    write_d      = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    clr_done_d   = 1'b0;
    case (state_q)
      ARB: begin
        if (bus.Clr_Start) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end else if (|gnt) begin
          last_gnt_d = gidx;
          // Protected r0 writes are still granted (consumed) but never issued.
          if (!(ZERO_PROTECT && addr[gidx] == '0)) begin
            write_d      = 1'b1;
            write_reg_d  = addr[gidx];
            write_data_d = wdata[gidx];
          end
        end
      end
      CLEAR: begin
        write_d      = 1'b1;
        write_reg_d  = clr_cnt_q;
        write_data_d = '0;
        clr_cnt_d    = clr_cnt_q + 1'b1;
        if (clr_cnt_q == CNT_MAX) begin
          state_d    = ARB;
          clr_done_d = 1'b1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= ARB;
      last_gnt_q   <= 1'b1;
      clr_cnt_q    <= '0;
      write_q      <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      clr_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_gnt_q   <= last_gnt_d;
      clr_cnt_q    <= clr_cnt_d;
      write_q      <= write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      clr_done_q   <= clr_done_d;
    end
  end

  assign bus.Gnt0       = gnt[0];
  assign bus.Gnt1       = gnt[1];
  assign bus.Busy       = (state_q == CLEAR);
  assign bus.Clr_Done   = clr_done_q;
  assign bus.Write      = write_q;
  assign bus.Write_Reg  = write_reg_q;
  assign bus.Write_Data = write_data_q;
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench: a ZERO_PROTECT=1 and a ZERO_PROTECT=0 instance share stimulus;
// vector table for arbitration, hand sequences for CLEAR and async reset.
module tb_regfile_write_scheduler;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NREG = 1 << AW;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  regfile_write_scheduler_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  regfile_write_scheduler_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_nz ();

  assign bus_nz.Req0      = bus.Req0;
  assign bus_nz.Addr0     = bus.Addr0;
  assign bus_nz.Data0     = bus.Data0;
  assign bus_nz.Req1      = bus.Req1;
  assign bus_nz.Addr1     = bus.Addr1;
  assign bus_nz.Data1     = bus.Data1;
  assign bus_nz.Clr_Start = bus.Clr_Start;

  regfile_write_scheduler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_PROTECT(1'b1))
    dut (.CLK(CLK), .RST(RST), .bus(bus));
  regfile_write_scheduler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_PROTECT(1'b0))
    dut_nz (.CLK(CLK), .RST(RST), .bus(bus_nz));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic r0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic r1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic clr);
    bus.Req0 = r0; bus.Addr0 = a0; bus.Data0 = d0;
    bus.Req1 = r1; bus.Addr1 = a1; bus.Data1 = d1;
    bus.Clr_Start = clr;
  endtask

  typedef struct {
    logic          r0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    logic          r1; logic [AW-1:0] a1; logic [DW-1:0] d1;
    logic          g0, g1;
    logic          w;     // expected Write, ZERO_PROTECT=1 instance
    logic          wnz;   // expected Write, ZERO_PROTECT=0 instance
    logic [AW-1:0] wreg;
    logic [DW-1:0] wdat;
  } vec_t;

  vec_t vt[13];

  // One CLEAR run: 32 writes 0..31, Busy throughout, one Clr_Done on the last.
  task automatic run_clear(input bit repulse, input bit req_pending);
    int done_cnt, wr_cnt;
    done_cnt = 0; wr_cnt = 0;
    bus.Clr_Start = 1'b1;
    #1;
    chk("start_gnt0", 32'(bus.Gnt0), 32'd0);
    tick();
    bus.Clr_Start = 1'b0;
    for (int k = 0; k < NREG; k++) begin
      if (repulse && k == 5) bus.Clr_Start = 1'b1;
      #1;
      chk($sformatf("clr_busy_%0d", k), 32'(bus.Busy), 32'd1);
      chk($sformatf("clr_gnt0_%0d", k), 32'(bus.Gnt0), 32'd0);
      tick();
      bus.Clr_Start = 1'b0;
      if (bus.Write) wr_cnt++;
      if (bus.Clr_Done) done_cnt++;
      chk($sformatf("clr_write_%0d", k), 32'(bus.Write), 32'd1);
      chk($sformatf("clr_reg_%0d", k), 32'(bus.Write_Reg), 32'(k));
      chk($sformatf("clr_data_%0d", k), bus.Write_Data, 32'd0);
      chk($sformatf("clr_done_%0d", k), 32'(bus.Clr_Done), 32'(k == NREG - 1));
    end
    chk("clr_busy_end", 32'(bus.Busy), 32'd0);
    chk("clr_gnt0_end", 32'(bus.Gnt0), 32'(req_pending));
    tick();
    if (bus.Clr_Done) done_cnt++;
    chk("clr_done_count", 32'(done_cnt), 32'd1);
    chk("clr_write_count", 32'(wr_cnt), 32'(NREG));
    chk("clr_after_busy", 32'(bus.Busy), 32'd0);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    // Arbitration after reset: Last_Gnt=1, so requester 0 wins the first tie.
    vt[0]  = '{0, 0, 0,          0, 0, 0,          0, 0, 0, 0, 0, 0};
    vt[1]  = '{1, 1, 32'h11,     1, 2, 32'h22,     1, 0, 1, 1, 1, 32'h11};
    vt[2]  = '{1, 1, 32'h11,     1, 2, 32'h22,     0, 1, 1, 1, 2, 32'h22};
    vt[3]  = '{1, 1, 32'h11,     1, 2, 32'h22,     1, 0, 1, 1, 1, 32'h11};
    vt[4]  = '{1, 1, 32'h11,     1, 2, 32'h22,     0, 1, 1, 1, 2, 32'h22};
    vt[5]  = '{0, 0, 0,          0, 0, 0,          0, 0, 0, 0, 0, 0};
    vt[6]  = '{1, 5, 32'hA5A5,   0, 0, 0,          1, 0, 1, 1, 5, 32'hA5A5};
    vt[7]  = '{0, 0, 0,          0, 0, 0,          0, 0, 0, 0, 0, 0};
    vt[8]  = '{0, 0, 0,          1, 0, 32'hFFFF,   0, 1, 0, 1, 0, 32'hFFFF};
    vt[9]  = '{1, 3, 32'h33,     1, 4, 32'h44,     1, 0, 1, 1, 3, 32'h33};
    vt[10] = '{1, 3, 32'h33,     1, 4, 32'h44,     0, 1, 1, 1, 4, 32'h44};
    vt[11] = '{0, 0, 0,          1, 0, 32'h1234,   0, 1, 0, 1, 0, 32'h1234};
    vt[12] = '{0, 0, 0,          0, 0, 0,          0, 0, 0, 0, 0, 0};

    #12;
    chk("rst_write", 32'(bus.Write), 32'd0);
    chk("rst_reg", 32'(bus.Write_Reg), 32'd0);
    chk("rst_data", bus.Write_Data, 32'd0);
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    chk("rst_done", 32'(bus.Clr_Done), 32'd0);
    tick();
    RST = 1'b1;

    foreach (vt[i]) begin
      drive(vt[i].r0, vt[i].a0, vt[i].d0, vt[i].r1, vt[i].a1, vt[i].d1, 0);
      #1;
      chk($sformatf("v%0d_gnt0", i), 32'(bus.Gnt0), 32'(vt[i].g0));
      chk($sformatf("v%0d_gnt1", i), 32'(bus.Gnt1), 32'(vt[i].g1));
      chk($sformatf("v%0d_busy", i), 32'(bus.Busy), 32'd0);
      tick();
      chk($sformatf("v%0d_write", i), 32'(bus.Write), 32'(vt[i].w));
      if (vt[i].w) begin
        chk($sformatf("v%0d_reg", i), 32'(bus.Write_Reg), 32'(vt[i].wreg));
        chk($sformatf("v%0d_data", i), bus.Write_Data, vt[i].wdat);
      end
      chk($sformatf("v%0d_nz_write", i), 32'(bus_nz.Write), 32'(vt[i].wnz));
      if (vt[i].wnz) begin
        chk($sformatf("v%0d_nz_reg", i), 32'(bus_nz.Write_Reg), 32'(vt[i].wreg));
        chk($sformatf("v%0d_nz_data", i), bus_nz.Write_Data, vt[i].wdat);
      end
      chk($sformatf("v%0d_done", i), 32'(bus.Clr_Done), 32'd0);
    end

    // CLEAR with Req0 pending: granted on the first ARB cycle.
    drive(1, 7, 32'h77, 0, 0, 0, 0);
    run_clear(1'b0, 1'b1);
    chk("post_clr_write", 32'(bus.Write), 32'd1);
    chk("post_clr_reg", 32'(bus.Write_Reg), 32'd7);
    chk("post_clr_data", bus.Write_Data, 32'h77);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("post_clr_idle", 32'(bus.Write), 32'd0);

    // Clr_Start re-pulsed mid-CLEAR is ignored.
    run_clear(1'b1, 1'b0);
    chk("repulse_idle_write", 32'(bus.Write), 32'd0);
    chk("repulse_idle_done", 32'(bus.Clr_Done), 32'd0);

    // Async reset at Clr_Cnt=10 aborts CLEAR without Clr_Done.
    bus.Clr_Start = 1'b1;
    tick();
    bus.Clr_Start = 1'b0;
    repeat (10) tick();
    chk("mid_reg9", 32'(bus.Write_Reg), 32'd9);
    #2;
    RST = 1'b0;
    #1;
    chk("arst_write", 32'(bus.Write), 32'd0);
    chk("arst_reg", 32'(bus.Write_Reg), 32'd0);
    chk("arst_data", bus.Write_Data, 32'd0);
    chk("arst_busy", 32'(bus.Busy), 32'd0);
    chk("arst_done", 32'(bus.Clr_Done), 32'd0);
    tick();
    RST = 1'b1;
    begin
      int done_seen = 0;
      for (int k = 0; k < NREG + 4; k++) begin
        tick();
        if (bus.Clr_Done || bus.Busy || bus.Write) done_seen++;
      end
      chk("arst_quiet", 32'(done_seen), 32'd0);
    end
    drive(1, 9, 32'h99, 0, 0, 0, 0);
    #1;
    chk("arst_gnt0", 32'(bus.Gnt0), 32'd1);
    tick();
    chk("arst_req_write", 32'(bus.Write), 32'd1);
    chk("arst_req_reg", 32'(bus.Write_Reg), 32'd9);
    chk("arst_req_data", bus.Write_Data, 32'h99);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Gnt0/Gnt1 exclusivity on both instances, sampled mid-cycle.
  always @(negedge CLK) begin
    if (RST && ((bus.Gnt0 && bus.Gnt1) || (bus_nz.Gnt0 && bus_nz.Gnt1))) begin
      n_cmp++;
      n_bad++;
      $display("FAIL gnt_exclusive: got both grants high expected at most one");
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
